// File: rtl/probe_conditioner.sv
// Probe pin conditioning: synchroniser, hysteretic deglitch integrator,
// edge pulses and a no-activity "stuck" flag for the X/Y probe channels.

module probe_conditioner_chan #(
  parameter int SYNC_STAGES  = 2,
  parameter int FILTER_WIDTH = 4,
  parameter int INVERT       = 0,
  parameter int STUCK_EXP    = 20
) (
  input  logic clk,
  input  logic rst_n,
  input  logic cg,
  input  logic pin,
  output logic lvl,
  output logic pulse,
  output logic stuck
);

  localparam logic [FILTER_WIDTH-1:0] FMAX = '1;
  localparam logic [FILTER_WIDTH-1:0] FMIN = '0;
  localparam logic [STUCK_EXP-1:0]    SMAX = '1;
  localparam logic                    INV  = (INVERT != 0);

  logic [SYNC_STAGES-1:0]  sync_q;
  logic [FILTER_WIDTH-1:0] cnt_q;
  logic [FILTER_WIDTH-1:0] cnt_d;
  logic [STUCK_EXP-1:0]    idle_q;
  logic                    s;
  logic                    lvl_d;
  logic                    chg;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], pin};
    end
  end

  assign s = sync_q[SYNC_STAGES-1] ^ INV;

  // Saturating integrator; the level only moves at the rails.
  always_comb begin
    cnt_d = cnt_q;
    if (s) begin
      if (cnt_q != FMAX) cnt_d = cnt_q + 1'b1;
    end else begin
      if (cnt_q != FMIN) cnt_d = cnt_q - 1'b1;
    end
    lvl_d = lvl;
    if (cnt_d == FMAX) lvl_d = 1'b1;
    else if (cnt_d == FMIN) lvl_d = 1'b0;
  end

  assign chg = (lvl_d != lvl);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q  <= '0;
      lvl    <= 1'b0;
      pulse  <= 1'b0;
      idle_q <= '0;
    end else if (cg) begin
      cnt_q <= cnt_d;
      lvl   <= lvl_d;
      pulse <= chg;
      if (chg) idle_q <= '0;
      else if (idle_q != SMAX) idle_q <= idle_q + 1'b1;
    end else begin
      pulse <= 1'b0;
    end
  end

  assign stuck = (idle_q == SMAX);

endmodule

module probe_conditioner #(
  parameter int SYNC_STAGES  = 2,
  parameter int FILTER_WIDTH = 4,
  parameter int INVERT_X     = 0,
  parameter int INVERT_Y     = 0,
  parameter int STUCK_EXP    = 20
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_cg,
  input  logic i_x,
  input  logic i_y,
  output logic o_x,
  output logic o_y,
  output logic o_xEdge,
  output logic o_yEdge,
  output logic o_xStuck,
  output logic o_yStuck
);

  probe_conditioner_chan #(
    .SYNC_STAGES (SYNC_STAGES),
    .FILTER_WIDTH(FILTER_WIDTH),
    .INVERT      (INVERT_X),
    .STUCK_EXP   (STUCK_EXP)
  ) u_x (
    .clk  (i_clk),
    .rst_n(i_rst_n),
    .cg   (i_cg),
    .pin  (i_x),
    .lvl  (o_x),
    .pulse(o_xEdge),
    .stuck(o_xStuck)
  );

  probe_conditioner_chan #(
    .SYNC_STAGES (SYNC_STAGES),
    .FILTER_WIDTH(FILTER_WIDTH),
    .INVERT      (INVERT_Y),
    .STUCK_EXP   (STUCK_EXP)
  ) u_y (
    .clk  (i_clk),
    .rst_n(i_rst_n),
    .cg   (i_cg),
    .pin  (i_y),
    .lvl  (o_y),
    .pulse(o_yEdge),
    .stuck(o_yStuck)
  );

endmodule

// File: tb/tb_probe_conditioner.sv
// Bench for probe_conditioner: directed latency/glitch/stuck/reset cases
// plus randomized pins and gating checked against a behavioural model.

module tb_probe_conditioner;

  localparam int SYNC = 2;
  localparam int FW   = 4;
  localparam int SE   = 6;
  localparam int FMAX = (1 << FW) - 1;
  localparam int SMAX = (1 << SE) - 1;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic cg = 1'b1;
  logic x = 1'b0;
  logic y = 1'b0;
  logic o_x, o_y, o_xEdge, o_yEdge, o_xStuck, o_yStuck;

  int checks = 0;
  int errors = 0;

  probe_conditioner #(
    .SYNC_STAGES (SYNC),
    .FILTER_WIDTH(FW),
    .INVERT_X    (0),
    .INVERT_Y    (0),
    .STUCK_EXP   (SE)
  ) dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .i_cg    (cg),
    .i_x     (x),
    .i_y     (y),
    .o_x     (o_x),
    .o_y     (o_y),
    .o_xEdge (o_xEdge),
    .o_yEdge (o_yEdge),
    .o_xStuck(o_xStuck),
    .o_yStuck(o_yStuck)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, got, exp, $time);
    end
  endtask

  // Behavioural model: pin history delayed by SYNC edges, clamped counts.
  bit hx[$];
  bit hy[$];
  int mc[2];
  int ms[2];
  bit ml[2];
  bit me[2];
  bit mvalid = 1'b0;

  always @(posedge clk) begin
    bit s[2];
    int nc;
    bit nl;
    if (!rst_n) begin
      hx.delete();
      hy.delete();
      for (int c = 0; c < 2; c++) begin
        mc[c] = 0; ms[c] = 0; ml[c] = 1'b0; me[c] = 1'b0;
      end
      mvalid = 1'b1;
    end else begin
      s[0] = (hx.size() >= SYNC) ? hx[hx.size() - SYNC] : 1'b0;
      s[1] = (hy.size() >= SYNC) ? hy[hy.size() - SYNC] : 1'b0;
      hx.push_back(x);
      hy.push_back(y);
      if (hx.size() > SYNC) void'(hx.pop_front());
      if (hy.size() > SYNC) void'(hy.pop_front());
      for (int c = 0; c < 2; c++) begin
        if (cg) begin
          nc = s[c] ? ((mc[c] < FMAX) ? mc[c] + 1 : FMAX)
                    : ((mc[c] > 0) ? mc[c] - 1 : 0);
          nl = (nc == FMAX) ? 1'b1 : (nc == 0) ? 1'b0 : ml[c];
          me[c] = (nl != ml[c]);
          ms[c] = me[c] ? 0 : ((ms[c] < SMAX) ? ms[c] + 1 : SMAX);
          mc[c] = nc;
          ml[c] = nl;
        end else begin
          me[c] = 1'b0;
        end
      end
    end
  end

  int xr = 0;
  int xf = 0;

  always @(negedge clk) begin
    if (mvalid) begin
      check("x_level", int'(o_x), int'(ml[0]));
      check("y_level", int'(o_y), int'(ml[1]));
      check("x_edge", int'(o_xEdge), int'(me[0]));
      check("y_edge", int'(o_yEdge), int'(me[1]));
      check("x_stuck", int'(o_xStuck), int'(ms[0] == SMAX));
      check("y_stuck", int'(o_yStuck), int'(ms[1] == SMAX));
    end
    if (o_xEdge && o_x) xr++;
    if (o_xEdge && !o_x) xf++;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
  endtask

  task automatic wait_x(input logic val, output int n);
    n = -1;
    for (int i = 1; i <= 200; i++) begin
      tick();
      if (o_x == val) begin
        n = i;
        break;
      end
    end
  endtask

  initial begin
    int n;
    int r0;
    int xrun;
    int yrun;

    // Step response from reset
    do_reset();
    x = 1'b1;
    y = 1'b0;
    wait_x(1'b1, n);
    check("latency_rise", n, 17);
    check("x_edge_on", int'(o_xEdge), 1);
    check("y_level_idle", int'(o_y), 0);
    tick();
    check("x_edge_off", int'(o_xEdge), 0);

    // Glitch rejection: 14 cycles rejected, 15 accepted
    x = 1'b0;
    repeat (40) tick();
    r0 = xr;
    x = 1'b1;
    repeat (14) tick();
    x = 1'b0;
    repeat (40) tick();
    check("glitch14_rises", xr - r0, 0);
    r0 = xr;
    x = 1'b1;
    repeat (15) tick();
    x = 1'b0;
    repeat (40) tick();
    check("pulse15_rises", xr - r0, 1);

    // Dip from settled high
    x = 1'b1;
    repeat (40) tick();
    r0 = xf;
    x = 1'b0;
    repeat (8) tick();
    x = 1'b1;
    repeat (40) tick();
    check("dip_falls", xf - r0, 0);
    check("dip_level", int'(o_x), 1);

    // Gated cycles mid-rise stretch the latency
    x = 1'b0;
    repeat (40) tick();
    x = 1'b1;
    n = -1;
    for (int i = 1; i <= 200; i++) begin
      tick();
      if (i == 8) cg = 1'b0;
      if (i == 13) cg = 1'b1;
      if (o_x) begin
        n = i;
        break;
      end
    end
    cg = 1'b1;
    check("latency_gated", n, 22);

    // Stuck flags after idle from reset
    x = 1'b0;
    y = 1'b0;
    do_reset();
    n = -1;
    for (int i = 1; i <= 200; i++) begin
      tick();
      if (o_xStuck) begin
        n = i;
        break;
      end
    end
    check("stuck_cycles", n, SMAX);
    check("y_stuck_same", int'(o_yStuck), 1);
    x = 1'b1;
    n = -1;
    for (int i = 1; i <= 200; i++) begin
      tick();
      if (o_xEdge) begin
        n = i;
        break;
      end
    end
    check("stuck_edge_lat", n, 17);
    check("x_stuck_clear", int'(o_xStuck), 0);
    check("y_stuck_hold", int'(o_yStuck), 1);

    // Mid-operation reset
    repeat (70) tick();
    check("pre_rst_x", int'(o_x), 1);
    check("pre_rst_stuck", int'(o_xStuck), 1);
    rst_n = 1'b0;
    tick();
    check("rst_outputs",
          int'({o_x, o_y, o_xEdge, o_yEdge, o_xStuck, o_yStuck}), 0);
    rst_n = 1'b1;
    wait_x(1'b1, n);
    check("latency_after_rst", n, 17);

    // Randomized pins, gating and rare resets
    xrun = 0;
    yrun = 0;
    for (int k = 0; k < 4000; k++) begin
      if (xrun == 0) begin
        x = 1'($urandom_range(0, 1));
        xrun = $urandom_range(1, 30);
      end
      if (yrun == 0) begin
        y = 1'($urandom_range(0, 1));
        yrun = $urandom_range(1, 30);
      end
      xrun--;
      yrun--;
      cg = ($urandom_range(0, 9) != 0);
      rst_n = ($urandom_range(0, 999) != 0);
      tick();
    end
    rst_n = 1'b1;
    cg = 1'b1;
    repeat (5) tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
